// File: rtl/button_gesture_pkg.sv
// Shared types and default timing for the button gesture classifier.
// Default intervals assume the 12 MHz board clock.
package button_gesture_pkg;

    // Classifier states; the encoding is visible on the debug state port.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_HOLD   = 3'd2,
        ST_WAIT2  = 3'd3,
        ST_PRESS2 = 3'd4
    } state_t;

    // Which interval the shared counter is currently compared against.
    typedef enum logic [1:0] {
        LIM_LONG   = 2'd0,
        LIM_REPEAT = 2'd1,
        LIM_DCLICK = 2'd2
    } lim_sel_t;

    localparam int unsigned CLK_HZ            = 12_000_000;
    localparam int unsigned DEF_CNT_W         = 24;
    localparam int unsigned DEF_LONG_CYCLES   = CLK_HZ / 2;   // 500 ms hold
    localparam int unsigned DEF_DCLICK_CYCLES = CLK_HZ / 4;   // 250 ms gap
    localparam int unsigned DEF_REPEAT_CYCLES = CLK_HZ / 10;  // 100 ms repeat

    // Limit that applies while sitting in a given state.
    function automatic lim_sel_t lim_for_state(input state_t s);
        case (s)
            ST_PRESS1: return LIM_LONG;
            ST_HOLD:   return LIM_REPEAT;
            default:   return LIM_DCLICK;
        endcase
    endfunction

endpackage

// File: rtl/button_gesture_timer.sv
// Shared interval counter with clear/enable and a terminal-count flag.
// o_tc is high when the count equals (selected limit - 1), so a state that
// acts on o_tc has spent exactly "limit" cycles since it was entered.
module button_gesture_timer
    import button_gesture_pkg::*;
#(
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned DCLICK_CYCLES = DEF_DCLICK_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic     i_clk,
    input  logic     i_resetn,
    input  logic     i_clr,
    input  logic     i_cnt_en,
    input  lim_sel_t i_lim_sel,
    output logic     o_tc
);

    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCLICK_TC = CNT_W'(DCLICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_tc_val;

    // Pick the terminal value for the active interval.
    always_comb begin
        w_tc_val = DCLICK_TC;
        case (i_lim_sel)
            LIM_LONG:   w_tc_val = LONG_TC;
            LIM_REPEAT: w_tc_val = REPEAT_TC;
            default:    w_tc_val = DCLICK_TC;
        endcase
    end

    // Counter: clear wins over count; saturates rather than wrapping.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_cnt_en && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == w_tc_val);

endmodule

// File: rtl/button_gesture.sv
// Classifies debounced button activity into single-cycle gesture pulses:
// click, double_click, long_press and auto-repeat. All outputs registered.
// Inputs are level/pulse signals from the debouncer (no handshake); each
// output pulse is high for one cycle and is not acknowledged by the consumer.
module button_gesture
    import button_gesture_pkg::*;
#(
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned DCLICK_CYCLES = DEF_DCLICK_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic   i_clk,
    input  logic   i_resetn,
    input  logic   i_en,
    input  logic   i_pb_state,
    input  logic   i_pb_down,
    input  logic   i_pb_up,
    output logic   o_click,
    output logic   o_double_click,
    output logic   o_long_press,
    output logic   o_repeat_evt,
    output logic   o_busy,
    output state_t o_state
);

    state_t   r_state;
    logic     r_click;
    logic     r_double_click;
    logic     r_long_press;
    logic     r_repeat_evt;
    logic     r_busy;

    state_t   w_nxt;
    logic     w_reload;
    logic     w_click;
    logic     w_double_click;
    logic     w_long_press;
    logic     w_repeat_evt;
    logic     w_clr;
    logic     w_cnt_en;
    logic     w_tc;
    lim_sel_t w_lim_sel;

    // Interval timing; the counter restarts on every state entry or reload.
    assign w_lim_sel = lim_for_state(r_state);
    assign w_cnt_en  = (r_state == ST_PRESS1) || (r_state == ST_HOLD) ||
                       (r_state == ST_WAIT2);
    assign w_clr     = (w_nxt != r_state) || w_reload || !i_en;

    button_gesture_timer #(
        .CNT_W         (CNT_W),
        .LONG_CYCLES   (LONG_CYCLES),
        .DCLICK_CYCLES (DCLICK_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_timer (
        .i_clk     (i_clk),
        .i_resetn  (i_resetn),
        .i_clr     (w_clr),
        .i_cnt_en  (w_cnt_en),
        .i_lim_sel (w_lim_sel),
        .o_tc      (w_tc)
    );

    // Transition and event decode. Edge pulses take priority over timeouts;
    // a level that disagrees with the state (lost edge) is trusted next.
    always_comb begin
        w_nxt          = r_state;
        w_reload       = 1'b0;
        w_click        = 1'b0;
        w_double_click = 1'b0;
        w_long_press   = 1'b0;
        w_repeat_evt   = 1'b0;
        if (!i_en) begin
            w_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_pb_down) w_nxt = ST_PRESS1;
                end
                ST_PRESS1: begin
                    if (i_pb_up) begin
                        w_nxt = ST_WAIT2;
                    end else if (!i_pb_state) begin
                        w_nxt = ST_IDLE;
                    end else if (w_tc) begin
                        w_nxt        = ST_HOLD;
                        w_long_press = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (i_pb_up || !i_pb_state) begin
                        w_nxt = ST_IDLE;
                    end else if (w_tc) begin
                        w_reload     = 1'b1;
                        w_repeat_evt = 1'b1;
                    end
                end
                ST_WAIT2: begin
                    if (i_pb_down || i_pb_state) begin
                        w_nxt = ST_PRESS2;
                    end else if (w_tc) begin
                        w_nxt   = ST_IDLE;
                        w_click = 1'b1;
                    end
                end
                ST_PRESS2: begin
                    if (i_pb_up) begin
                        w_nxt          = ST_IDLE;
                        w_double_click = 1'b1;
                    end else if (!i_pb_state) begin
                        w_nxt = ST_IDLE;
                    end
                end
                default: w_nxt = ST_IDLE;
            endcase
        end
    end

    // State register with registered event pulses and busy flag.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state        <= ST_IDLE;
            r_click        <= 1'b0;
            r_double_click <= 1'b0;
            r_long_press   <= 1'b0;
            r_repeat_evt   <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_nxt;
            r_click        <= w_click;
            r_double_click <= w_double_click;
            r_long_press   <= w_long_press;
            r_repeat_evt   <= w_repeat_evt;
            r_busy         <= (w_nxt != ST_IDLE);
        end
    end

    assign o_click        = r_click;
    assign o_double_click = r_double_click;
    assign o_long_press   = r_long_press;
    assign o_repeat_evt   = r_repeat_evt;
    assign o_busy         = r_busy;
    assign o_state        = r_state;

endmodule

// File: tb/tb_button_gesture.sv
// Bench for button_gesture: directed gestures from the test plan followed by
// randomized button activity, checked against a timestamp-based model.
module tb_button_gesture;
    import button_gesture_pkg::*;

    localparam int CNT_W  = 8;
    localparam int LONG   = 8;
    localparam int DCLICK = 6;
    localparam int REPEAT = 4;

    // Event codes used by the model and the monitor.
    localparam logic [2:0] EV_CLICK = 3'd1;
    localparam logic [2:0] EV_DBL   = 3'd2;
    localparam logic [2:0] EV_LONG  = 3'd3;
    localparam logic [2:0] EV_REP   = 3'd4;

    // Model phases of a gesture.
    localparam int P_IDLE  = 0;
    localparam int P_HELD1 = 1;
    localparam int P_LONG  = 2;
    localparam int P_GAP   = 3;
    localparam int P_HELD2 = 4;

    logic   clk;
    logic   i_resetn, i_en, i_pb_state, i_pb_down, i_pb_up;
    logic   o_click, o_double_click, o_long_press, o_repeat_evt, o_busy;
    state_t o_state;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Scoreboard queues: {cycle, event code} and {cycle, busy}.
    logic [34:0] exp_q[$];
    logic [32:0] busy_q[$];

    // Model state: phase plus the cycle its current interval started.
    int ph    = P_IDLE;
    int t_ref = 0;

    bit held  = 0;
    bit rst_v = 0;
    bit en_v  = 1;

    button_gesture #(
        .CNT_W         (CNT_W),
        .LONG_CYCLES   (LONG),
        .DCLICK_CYCLES (DCLICK),
        .REPEAT_CYCLES (REPEAT)
    ) dut (
        .i_clk          (clk),
        .i_resetn       (i_resetn),
        .i_en           (i_en),
        .i_pb_state     (i_pb_state),
        .i_pb_down      (i_pb_down),
        .i_pb_up        (i_pb_up),
        .o_click        (o_click),
        .o_double_click (o_double_click),
        .o_long_press   (o_long_press),
        .o_repeat_evt   (o_repeat_evt),
        .o_busy         (o_busy),
        .o_state        (o_state)
    );

    // Clock and cycle index (cycle c is the interval ending at edge c).
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: given cycle c's inputs, predict events and busy for c+1
    // from elapsed-time rules (hold length, release gap, repeat period).
    task automatic model_step(input int c, input bit rn, input bit en,
                              input bit st, input bit dn, input bit up);
        logic [2:0] ev;
        ev = 3'd0;
        if (!rn || !en) begin
            ph = P_IDLE;
        end else begin
            case (ph)
                P_IDLE: if (dn) begin ph = P_HELD1; t_ref = c; end
                P_HELD1: begin
                    if (up) begin ph = P_GAP; t_ref = c; end
                    else if (!st) ph = P_IDLE;
                    else if (c - t_ref == LONG) begin ev = EV_LONG; ph = P_LONG; t_ref = c; end
                end
                P_LONG: begin
                    if (up || !st) ph = P_IDLE;
                    else if (c - t_ref == REPEAT) begin ev = EV_REP; t_ref = c; end
                end
                P_GAP: begin
                    if (dn || st) ph = P_HELD2;
                    else if (c - t_ref == DCLICK) begin ev = EV_CLICK; ph = P_IDLE; end
                end
                default: begin
                    if (up) begin ev = EV_DBL; ph = P_IDLE; end
                    else if (!st) ph = P_IDLE;
                end
            endcase
        end
        if (ev != 3'd0) exp_q.push_back({32'(c + 1), ev});
        busy_q.push_back({32'(c + 1), (ph != P_IDLE)});
    endtask

    // Driver: apply one cycle of inputs, tell the model, advance to next cycle.
    task automatic drive_raw(input bit st, input bit dn, input bit up);
        i_resetn   = rst_v;
        i_en       = en_v;
        i_pb_state = st;
        i_pb_down  = dn;
        i_pb_up    = up;
        model_step(cyc, rst_v, en_v, st, dn, up);
        @(posedge clk);
        #1;
    endtask

    // Well-formed debouncer output: level follows the press/release pulses.
    task automatic tick(input bit dn, input bit up);
        if (dn) held = 1;
        if (up) held = 0;
        drive_raw(held, dn, up);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0);
    endtask

    // Monitor: busy every cycle; event pulses popped against the queue.
    always @(negedge clk) begin
        logic [3:0]  pulses;
        logic [2:0]  act;
        logic [34:0] e;
        logic [32:0] b;
        if (cyc >= 1) begin
            if (busy_q.size() > 0 && int'(busy_q[0][32:1]) == cyc) begin
                b = busy_q.pop_front();
                n_assert++;
                if (o_busy !== b[0]) begin
                    n_fail++;
                    $display("FAIL busy cycle %0d: got %b (state %0d) expected %b",
                             cyc, o_busy, o_state, b[0]);
                end
            end
            pulses = {o_repeat_evt, o_long_press, o_double_click, o_click};
            if (pulses !== 4'b0000) begin
                n_assert++;
                if ($countones(pulses) != 1) begin
                    n_fail++;
                    $display("FAIL onehot cycle %0d: pulses %b expected at most one", cyc, pulses);
                end
                act = o_click ? EV_CLICK : o_double_click ? EV_DBL :
                      o_long_press ? EV_LONG : EV_REP;
                n_assert++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL event cycle %0d: got code %0d expected none", cyc, act);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(e[34:3]) != cyc || e[2:0] != act) begin
                        n_fail++;
                        $display("FAIL event cycle %0d: got code %0d expected code %0d at cycle %0d",
                                 cyc, act, e[2:0], int'(e[34:3]));
                    end
                end
            end
            while (exp_q.size() > 0 && int'(exp_q[0][34:3]) <= cyc) begin
                e = exp_q.pop_front();
                n_assert++;
                n_fail++;
                $display("FAIL missed_event cycle %0d: got none expected code %0d", cyc, e[2:0]);
            end
        end
    end

    // Stimulus: directed test-plan cases, then randomized activity.
    initial begin
        int r;
        int rel_range;
        rst_v = 0;
        idle(2);
        rst_v = 1;
        idle(3);

        // Click: down@0 up@3 -> click at 10.
        tick(1, 0); idle(2); tick(0, 1); idle(12);
        // Double click: down@0 up@2 down@5 up@7 -> double at 8.
        tick(1, 0); idle(1); tick(0, 1); idle(2); tick(1, 0); idle(1); tick(0, 1); idle(12);
        // Long press with repeats, release @22.
        tick(1, 0); idle(21); tick(0, 1); idle(12);
        // Tie: release on the long-press edge -> no long_press, then click.
        tick(1, 0); idle(7); tick(0, 1); idle(12);
        // Tie: second press on the click timeout edge -> double click.
        tick(1, 0); idle(2); tick(0, 1); idle(5); tick(1, 0); idle(1); tick(0, 1); idle(12);
        // Reset while in HOLD.
        tick(1, 0); idle(12); rst_v = 0; idle(1); rst_v = 1; idle(3); tick(0, 1); idle(10);
        // Enable dropped in WAIT2 -> no click.
        tick(1, 0); idle(1); tick(0, 1); idle(2); en_v = 0; idle(1); en_v = 1; idle(12);
        // Lost release edge in PRESS1.
        tick(1, 0); idle(2); held = 0; drive_raw(0, 0, 0); idle(12);

        // Randomized activity in blocks with different hold/gap tempos.
        for (int blk = 0; blk < 12; blk++) begin
            rel_range = (blk % 3 == 0) ? 3 : ((blk % 3 == 1) ? 10 : 24);
            for (int k = 0; k < 200; k++) begin
                r = int'($urandom_range(0, 999));
                if (r < 8) begin
                    rst_v = 0; tick(0, 0); rst_v = 1;
                end else if (r < 16) begin
                    en_v = 0; tick(0, 0); en_v = 1;
                end else if (r < 22) begin
                    held = !held; drive_raw(held, 0, 0);
                end else if (r < 30) begin
                    drive_raw(held, held, !held);
                end else if (held) begin
                    if ($urandom_range(0, rel_range - 1) == 0) tick(0, 1); else tick(0, 0);
                end else begin
                    if ($urandom_range(0, rel_range / 2) == 0) tick(1, 0); else tick(0, 0);
                end
            end
        end
        if (held) tick(0, 1);
        idle(30);

        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d events outstanding expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/button_gesture.md
Name: button_gesture

Overview:
Sits directly downstream of the push-button debouncer and consumes its clean, clk-synchronous pb_state, pb_down and pb_up outputs. Classifies button activity into single-cycle gesture events: click, double_click, long_press and auto-repeat. Feeds UI/font-control logic (cursor step, page change, hold-to-scroll) so that consumers never time button presses themselves.

Parameters:
CNT_W, 24, width of the shared interval counter
LONG_CYCLES, 24'd6_000_000, hold duration that makes a press "long" (>=2, < 2^CNT_W)
DCLICK_CYCLES, 24'd3_000_000, maximum release gap before a second press counts as a double click (>=2)
REPEAT_CYCLES, 24'd1_200_000, auto-repeat period while a long press is held (>=2)

Ports:
clk  in  1  system clock, same clock as the debouncer
resetn  in  1  synchronous, active-low reset
en  in  1  1 = classify; 0 = state forced to IDLE and no events emitted
pb_state  in  1  debounced level, 1 = button held
pb_down  in  1  one-cycle pulse on debounced press
pb_up  in  1  one-cycle pulse on debounced release
click  out  1  one-cycle pulse: single short press confirmed
double_click  out  1  one-cycle pulse: second press released inside the gap window
long_press  out  1  one-cycle pulse: hold reached LONG_CYCLES
repeat_evt  out  1  one-cycle pulse every REPEAT_CYCLES while held after long_press
busy  out  1  1 whenever state != IDLE (registered)

Behaviour:
- Reset: when resetn=0 at a clk edge -> state IDLE, cnt=0, all outputs 0. Reset mid-gesture emits no pending event.
- All outputs are registered. An event pulse is high for exactly one cycle, in the cycle after the edge that sampled its trigger condition.
- At most one of click, double_click, long_press or repeat_evt is high in any cycle.
- cnt is zeroed on every state entry. It increments by 1 each cycle inside a state and never wraps, because every state leaves or reloads before its limit.
- en=0 behaves like a soft reset of state/cnt but does not gate resetn. Pulses already registered still complete their single cycle.
- States and transitions (evaluated each edge, en=1):
  - IDLE: pb_down -> PRESS1.
  - PRESS1:
    - pb_up -> WAIT2.
    - Else if cnt==LONG_CYCLES-1 -> emit long_press, go to HOLD.
    - pb_up wins if both happen in the same cycle.
  - HOLD:
    - pb_up -> IDLE, no event.
    - Else if cnt==REPEAT_CYCLES-1 -> emit repeat_evt, reload cnt=0.
    - pb_up wins over repeat in the same cycle.
  - WAIT2:
    - pb_down -> PRESS2.
    - Else if cnt==DCLICK_CYCLES-1 -> emit click, go to IDLE.
    - pb_down wins over timeout in the same cycle (result is a double click).
  - PRESS2: pb_up -> emit double_click, go to IDLE, regardless of hold length; no long_press is emitted from PRESS2.
- Lost-edge recovery: in PRESS1, HOLD or PRESS2, pb_state==0 with no pb_up -> IDLE, no event. In WAIT2, pb_state==1 with no pb_down -> PRESS2.
- pb_down in PRESS1/HOLD/PRESS2 and pb_up in IDLE/WAIT2 are ignored.
- Latency from the pb_down sample edge:
  - long_press is high LONG_CYCLES+1 cycles later.
  - click is high DCLICK_CYCLES+1 cycles after the pb_up sample edge.

Decomposition:
- Shared include file button_pkg.vh holds:
  - state encodings: ST_IDLE, ST_PRESS1, ST_HOLD, ST_WAIT2, ST_PRESS2 (3 bits);
  - default timing localparams derived from the 12 MHz board clock.
- One natural sub-module: gesture_timer (clear/enable counter with terminal-count compare against a selected limit).
- State register and output decode remain in button_gesture.

Test Plan (CNT_W=8, LONG=8, DCLICK=6, REPEAT=4):
- Click: pb_down@0, pb_up@3, idle -> click high at cycle 10 only; no other events.
- Double click: pb_down@0, pb_up@2, pb_down@5, pb_up@7 -> double_click high at cycle 8; click never asserted.
- Long press with repeat: pb_down@0, hold until pb_up@22 -> long_press@9, repeat_evt@13, 17, 21; nothing after release; busy falls at 23.
- Boundary ties:
  - pb_up on the same edge PRESS1 hits cnt=7 -> no long_press, enters WAIT2.
  - pb_down on the WAIT2 timeout edge -> PRESS2, no click.
- Reset and enable: resetn=0 for 1 cycle while in HOLD -> all outputs 0 next cycle, IDLE, no event. Likewise, en=0 in WAIT2 -> no click ever emitted.
- Lost edge: force pb_state=0 while in PRESS1 without pb_up -> IDLE next cycle, busy=0, no pulses.
